// File: rtl/dsp_wresp_arbiter_if.sv
// B-channel bundle between the slave-side response sources, the write-response arbiter and the master.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface dsp_wresp_arbiter_if #(
    parameter int SLV_AMT         = 2,
    parameter int TRANS_MST_ID_W  = 5,
    parameter int TRANS_WR_RESP_W = 2
);
    logic [TRANS_MST_ID_W*SLV_AMT-1:0]  sa_BID_i;
    logic [TRANS_WR_RESP_W*SLV_AMT-1:0] sa_BRESP_i;
    logic [SLV_AMT-1:0]                 sa_BVALID_i;
    logic [SLV_AMT-1:0]                 sa_BREADY_o;
    logic [TRANS_MST_ID_W-1:0]          m_BID_o;
    logic [TRANS_WR_RESP_W-1:0]         m_BRESP_o;
    logic                               m_BVALID_o;
    logic                               m_BREADY_i;
    logic                               AW_shift_en_i;
    logic                               AW_stall_o;

    modport slave (
        input  sa_BID_i, sa_BRESP_i, sa_BVALID_i, m_BREADY_i, AW_shift_en_i,
        output sa_BREADY_o, m_BID_o, m_BRESP_o, m_BVALID_o, AW_stall_o
    );

    modport master (
        output sa_BID_i, sa_BRESP_i, sa_BVALID_i, m_BREADY_i, AW_shift_en_i,
        input  sa_BREADY_o, m_BID_o, m_BRESP_o, m_BVALID_o, AW_stall_o
    );
endinterface

// File: rtl/dsp_wresp_arbiter.sv
// Per-master write-response arbiter: picks one slave-side B response per cycle into a one-entry
// output buffer and tracks outstanding writes. Define DSP_WRESP_RR_EN for round-robin, else fixed priority.
module dsp_wresp_arbiter #(
    parameter int SLV_AMT         = 2,
    parameter int OUTSTANDING_AMT = 8,
    parameter int TRANS_MST_ID_W  = 5,
    parameter int TRANS_WR_RESP_W = 2
) (
    input  logic                 ACLK_i,
    input  logic                 ARESETn_i,
    dsp_wresp_arbiter_if.slave   bus
);
    localparam int IDX_W = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1;
    localparam int OC_W  = $clog2(OUTSTANDING_AMT + 1);
    localparam logic [OC_W-1:0] OC_MAX = OC_W'(OUTSTANDING_AMT);

    logic [IDX_W-1:0]           grant;
    logic                       any_vld;
    logic                       load_en;
    logic                       src_hs;
    logic                       mst_hs;
    logic [TRANS_MST_ID_W-1:0]  sel_bid;
    logic [TRANS_WR_RESP_W-1:0] sel_bresp;

    logic                       bvalid_q, bvalid_d;
    logic [TRANS_MST_ID_W-1:0]  bid_q, bid_d;
    logic [TRANS_WR_RESP_W-1:0] bresp_q, bresp_d;
    logic [OC_W-1:0]            oc_q, oc_d;

    // Saturating up/down step; simultaneous inc and dec cancel out.
    function automatic logic [OC_W-1:0] oc_sat_step(input logic [OC_W-1:0] oc,
                                                    input logic inc, input logic dec);
        logic [OC_W-1:0] r;
        r = oc;
        if (inc && !dec && (oc != OC_MAX)) r = oc + 1'b1;
        if (dec && !inc && (oc != '0))     r = oc - 1'b1;
        return r;
    endfunction

    assign any_vld = |bus.sa_BVALID_i;
    assign load_en = ~bvalid_q | bus.m_BREADY_i;
    assign src_hs  = load_en & any_vld;
    assign mst_hs  = bvalid_q & bus.m_BREADY_i;

`ifdef DSP_WRESP_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // First valid at or above the pointer wins; otherwise wrap to the lowest valid index.
    always_comb begin
        logic [IDX_W-1:0] grant_hi;
        logic [IDX_W-1:0] grant_lo;
        logic             found_hi;
        grant_hi = '0;
        grant_lo = '0;
        found_hi = 1'b0;
        for (int k = SLV_AMT - 1; k >= 0; k--) begin
            if (bus.sa_BVALID_i[k]) begin
                grant_lo = IDX_W'(k);
                if (IDX_W'(k) >= rr_ptr_q) begin
                    grant_hi = IDX_W'(k);
                    found_hi = 1'b1;
                end
            end
        end
        grant = found_hi ? grant_hi : grant_lo;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (src_hs) rr_ptr_d = (grant == IDX_W'(SLV_AMT - 1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) rr_ptr_q <= '0;
        else            rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        grant = '0;
        for (int k = SLV_AMT - 1; k >= 0; k--) begin
            if (bus.sa_BVALID_i[k]) grant = IDX_W'(k);
        end
    end
`endif

    always_comb begin
        sel_bid   = '0;
        sel_bresp = '0;
        for (int k = 0; k < SLV_AMT; k++) begin
            bus.sa_BREADY_o[k] = src_hs & (grant == IDX_W'(k));
            if (grant == IDX_W'(k)) begin
                sel_bid   = bus.sa_BID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                sel_bresp = bus.sa_BRESP_i[k*TRANS_WR_RESP_W +: TRANS_WR_RESP_W];
            end
        end
    end

    // A new response may load in the same cycle the old one drains; payload holds after a plain drain.
    always_comb begin
        bvalid_d = bvalid_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        if (src_hs) begin
            bvalid_d = 1'b1;
            bid_d    = sel_bid;
            bresp_d  = sel_bresp;
        end else if (mst_hs) begin
            bvalid_d = 1'b0;
        end
        oc_d = oc_sat_step(oc_q, bus.AW_shift_en_i, mst_hs);
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= '0;
            oc_q     <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            oc_q     <= oc_d;
        end
    end

    assign bus.m_BVALID_o = bvalid_q;
    assign bus.m_BID_o    = bid_q;
    assign bus.m_BRESP_o  = bresp_q;
    assign bus.AW_stall_o = (oc_q == OC_MAX);
endmodule

// File: tb/tb_dsp_wresp_arbiter.sv
// Bench for dsp_wresp_arbiter: directed vector table, hand sequences for multi-cycle corners,
// and random traffic against a cycle-level reference model.
module tb_dsp_wresp_arbiter;
    localparam int N  = 2;
    localparam int IW = 5;
    localparam int RW = 2;
    localparam int OA = 8;

    logic clk;
    logic ARESETn;

    dsp_wresp_arbiter_if #(.SLV_AMT(N), .TRANS_MST_ID_W(IW), .TRANS_WR_RESP_W(RW)) bus ();

    dsp_wresp_arbiter #(
        .SLV_AMT(N), .OUTSTANDING_AMT(OA), .TRANS_MST_ID_W(IW), .TRANS_WR_RESP_W(RW)
    ) dut (
        .ACLK_i(clk),
        .ARESETn_i(ARESETn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Current stimulus, kept locally so the model never reads the DUT
    logic [N-1:0]  cur_vld;
    logic [IW-1:0] cur_id [N];
    logic [RW-1:0] cur_rs [N];
    logic          cur_rdy;
    logic          cur_aw;

    // Reference model state
    bit            mv;
    int            mid;
    int            mrs;
    int            mptr;
    int            moc;

    typedef struct {
        logic [1:0]  vld;
        logic [4:0]  id1, id0;
        logic [1:0]  rs1, rs0;
        logic        rdy, aw;
        logic [1:0]  e_brdy;
        logic        e_bv;
        logic [4:0]  e_bid;
        logic [1:0]  e_brs;
        logic        e_stall;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            int k;
`ifdef DSP_WRESP_RR_EN
            k = (mptr + off) % N;
`else
            k = off;
`endif
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        mv = 0; mid = 0; mrs = 0; mptr = 0; moc = 0;
    endfunction

    task automatic apply(input logic [1:0] vld, input logic [4:0] id1, input logic [4:0] id0,
                         input logic [1:0] rs1, input logic [1:0] rs0,
                         input logic rdy, input logic aw);
        @(negedge clk);
        cur_vld = vld; cur_id[1] = id1; cur_id[0] = id0;
        cur_rs[1] = rs1; cur_rs[0] = rs0; cur_rdy = rdy; cur_aw = aw;
        bus.sa_BVALID_i   = vld;
        bus.sa_BID_i      = {id1, id0};
        bus.sa_BRESP_i    = {rs1, rs0};
        bus.m_BREADY_i    = rdy;
        bus.AW_shift_en_i = aw;
        #1;
    endtask

    task automatic model_check();
        int   g;
        logic hs;
        logic [1:0] e;
        g  = model_grant(cur_vld);
        hs = (!mv || cur_rdy) && (cur_vld != 0);
        e  = hs ? (2'b01 << g) : 2'b00;
        chk("m.sa_BREADY", 32'(bus.sa_BREADY_o), 32'(e));
        chk("m.m_BVALID",  32'(bus.m_BVALID_o),  32'(mv));
        chk("m.m_BID",     32'(bus.m_BID_o),     32'(mid));
        chk("m.m_BRESP",   32'(bus.m_BRESP_o),   32'(mrs));
        chk("m.AW_stall",  32'(bus.AW_stall_o),  32'(moc == OA));
    endtask

    // Advance the model across the coming rising edge
    function automatic void model_adv();
        int   g;
        bit   hs, mhs;
        g   = model_grant(cur_vld);
        hs  = (!mv || cur_rdy) && (cur_vld != 0);
        mhs = mv && cur_rdy;
        if (hs) begin
            mv = 1; mid = int'(cur_id[g]); mrs = int'(cur_rs[g]);
            mptr = (g + 1) % N;
        end else if (mhs) begin
            mv = 0;
        end
        moc = moc + int'(cur_aw) - int'(mhs);
        if (moc > OA) moc = OA;
        if (moc < 0)  moc = 0;
    endfunction

    task automatic step(input logic [1:0] vld, input logic [4:0] id1, input logic [4:0] id0,
                        input logic [1:0] rs1, input logic [1:0] rs0,
                        input logic rdy, input logic aw);
        apply(vld, id1, id0, rs1, rs0, rdy, aw);
        model_check();
        model_adv();
    endtask

    task automatic do_reset();
        @(negedge clk);
        ARESETn = 1'b0;
        bus.sa_BVALID_i = '0; bus.sa_BID_i = '0; bus.sa_BRESP_i = '0;
        bus.m_BREADY_i = 1'b0; bus.AW_shift_en_i = 1'b0;
        repeat (2) @(negedge clk);
        ARESETn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [4:0] exp_id;

        ARESETn = 1'b0;
        bus.sa_BVALID_i = '0; bus.sa_BID_i = '0; bus.sa_BRESP_i = '0;
        bus.m_BREADY_i = 1'b0; bus.AW_shift_en_i = 1'b0;
        model_reset();

        //          vld    id1    id0    rs1 rs0 rdy aw  brdy  bv bid   brs stall
        tbl[0] = '{2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 1, 0, 2'b00, 0, 5'h00, 2'd0, 0};
        tbl[1] = '{2'b10, 5'h0A, 5'h00, 2'd2, 2'd0, 1, 0, 2'b10, 0, 5'h00, 2'd0, 0};
        tbl[2] = '{2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 0, 2'b00, 1, 5'h0A, 2'd2, 0};
        tbl[3] = '{2'b01, 5'h00, 5'h11, 2'd0, 2'd1, 0, 0, 2'b00, 1, 5'h0A, 2'd2, 0};
        tbl[4] = '{2'b01, 5'h00, 5'h11, 2'd0, 2'd1, 1, 0, 2'b01, 1, 5'h0A, 2'd2, 0};
        tbl[5] = '{2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 1, 0, 2'b00, 1, 5'h11, 2'd1, 0};
        tbl[6] = '{2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 1, 0, 2'b00, 0, 5'h11, 2'd1, 0};

        do_reset();
        for (int r = 0; r < 7; r++) begin
            apply(tbl[r].vld, tbl[r].id1, tbl[r].id0, tbl[r].rs1, tbl[r].rs0, tbl[r].rdy, tbl[r].aw);
            chk("tbl.sa_BREADY", 32'(bus.sa_BREADY_o), 32'(tbl[r].e_brdy));
            chk("tbl.m_BVALID",  32'(bus.m_BVALID_o),  32'(tbl[r].e_bv));
            chk("tbl.m_BID",     32'(bus.m_BID_o),     32'(tbl[r].e_bid));
            chk("tbl.m_BRESP",   32'(bus.m_BRESP_o),   32'(tbl[r].e_brs));
            chk("tbl.AW_stall",  32'(bus.AW_stall_o),  32'(tbl[r].e_stall));
            model_check();
            model_adv();
        end

        // Contention: both sources valid, master always ready
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(2'b11, 5'h03, 5'h04, 2'd1, 2'd0, 1, 0);
`ifdef DSP_WRESP_RR_EN
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            chk("contention.grant", 32'(bus.sa_BREADY_o), 32'(exp_g));
            model_check();
            model_adv();
        end

        // Backpressure: buffered response must hold while both sources wait
        do_reset();
        step(2'b01, 5'h00, 5'h07, 2'd0, 2'd3, 1, 0);
        for (int i = 0; i < 5; i++) begin
            apply(2'b11, 5'h15, 5'h16, 2'd1, 2'd2, 0, 0);
            chk("bp.sa_BREADY", 32'(bus.sa_BREADY_o), 32'h0);
            chk("bp.m_BVALID",  32'(bus.m_BVALID_o),  32'h1);
            chk("bp.m_BID",     32'(bus.m_BID_o),     32'h07);
            chk("bp.m_BRESP",   32'(bus.m_BRESP_o),   32'h3);
            model_check();
            model_adv();
        end
        apply(2'b11, 5'h15, 5'h16, 2'd1, 2'd2, 1, 0);
`ifdef DSP_WRESP_RR_EN
        exp_g = 2'b10; exp_id = 5'h15;
`else
        exp_g = 2'b01; exp_id = 5'h16;
`endif
        chk("bp.release_grant", 32'(bus.sa_BREADY_o), 32'(exp_g));
        model_check();
        model_adv();
        apply(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 0);
        chk("bp.next_bid", 32'(bus.m_BID_o), 32'(exp_id));
        chk("bp.next_bvalid", 32'(bus.m_BVALID_o), 32'h1);
        model_check();
        model_adv();

        // Outstanding limit, drain, simultaneous inc/dec at full, saturation at full
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 1);
            chk("oc.fill_no_stall", 32'(bus.AW_stall_o), 32'h0);
            model_adv();
        end
        step(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 0);
        chk("oc.full_stall", 32'(bus.AW_stall_o), 32'h1);
        step(2'b01, 5'h00, 5'h09, 2'd0, 2'd0, 0, 0);
        step(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 1, 0);
        apply(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 0);
        chk("oc.drain_clears", 32'(bus.AW_stall_o), 32'h0);
        model_check(); model_adv();
        step(2'b01, 5'h00, 5'h09, 2'd0, 2'd0, 0, 1);
        apply(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 1, 1);
        chk("oc.both_at_full", 32'(bus.AW_stall_o), 32'h1);
        model_check(); model_adv();
        apply(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 1);
        chk("oc.both_keeps_full", 32'(bus.AW_stall_o), 32'h1);
        model_check(); model_adv();
        step(2'b01, 5'h00, 5'h09, 2'd0, 2'd0, 0, 0);
        step(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 1, 0);
        apply(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 0);
        chk("oc.saturated_then_drain", 32'(bus.AW_stall_o), 32'h0);
        model_check(); model_adv();

        // Asynchronous reset in the middle of traffic
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 1);
        step(2'b10, 5'h1F, 5'h00, 2'd1, 2'd0, 0, 0);
        apply(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 0);
        chk("rst.pre_bvalid", 32'(bus.m_BVALID_o), 32'h1);
        #1 ARESETn = 1'b0;
        #1;
        chk("rst.async_bvalid", 32'(bus.m_BVALID_o), 32'h0);
        chk("rst.async_bid",    32'(bus.m_BID_o),    32'h0);
        chk("rst.async_stall",  32'(bus.AW_stall_o), 32'h0);
        model_reset();
        @(negedge clk);
        ARESETn = 1'b1;
        apply(2'b11, 5'h02, 5'h01, 2'd0, 2'd0, 1, 0);
        chk("rst.first_grant", 32'(bus.sa_BREADY_o), 32'h1);
        model_check(); model_adv();
        for (int i = 0; i < 8; i++) step(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 1);
        apply(2'b00, 5'h00, 5'h00, 2'd0, 2'd0, 0, 0);
        chk("rst.counter_restart", 32'(bus.AW_stall_o), 32'h1);
        model_check(); model_adv();

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom),
                 2'($urandom), 2'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dsp_wresp_arbiter.md
# dsp_wresp_arbiter

Per-master write-response scheduler on the dispatcher side of the interconnect. It shares one master's B channel among `SLV_AMT` slave-side write-response channels, each already filtered and demapped to that master. It picks one pending response per cycle, buffers it in a single-entry output register and forwards it to the master. It also tracks the master's outstanding write transactions and stalls the write-address path when the outstanding budget is exhausted.

## Interface
Parameters:
- `SLV_AMT`, 2: number of slave-side B sources, ≥2.
- `OUTSTANDING_AMT`, 8: maximum outstanding writes for this master.
- `TRANS_MST_ID_W`, 5: master transaction ID width.
- `TRANS_WR_RESP_W`, 2: BRESP width.

Ports:
- `ACLK_i`, in, 1: clock, rising edge.
- `ARESETn_i`, in, 1: asynchronous active-low reset.
- `sa_BID_i`, in, `TRANS_MST_ID_W*SLV_AMT`: per-source BID, source k at slice k.
- `sa_BRESP_i`, in, `TRANS_WR_RESP_W*SLV_AMT`: per-source BRESP.
- `sa_BVALID_i`, in, `SLV_AMT`: per-source BVALID.
- `sa_BREADY_o`, out, `SLV_AMT`: per-source BREADY; at most one bit high.
- `m_BID_o`, out, `TRANS_MST_ID_W`: BID to the master.
- `m_BRESP_o`, out, `TRANS_WR_RESP_W`: BRESP to the master.
- `m_BVALID_o`, out, 1: BVALID to the master.
- `m_BREADY_i`, in, 1: BREADY from the master.
- `AW_shift_en_i`, in, 1: pulse marking one AW transaction accepted for this master.
- `AW_stall_o`, out, 1: high when the outstanding count equals `OUTSTANDING_AMT`.

## Operation
- Output buffer: one entry holding `{valid, BID, BRESP}` that drives `m_*` directly.
- `load_en = ~m_BVALID_o | m_BREADY_i`. The buffer can take a new response even in the cycle it is being drained.
- Arbitration: round-robin. The search starts at pointer `rr_ptr` and takes the first k in order `rr_ptr, rr_ptr+1, …` (mod `SLV_AMT`) with `sa_BVALID_i[k]=1`. That k is `grant`.
- `sa_BREADY_o[grant] = load_en & any(sa_BVALID_i)`. All other bits are 0.
  - `sa_BREADY_o` may be combinationally dependent on `m_BREADY_i`.
  - It never depends on `sa_BVALID_i` of a non-granted source in a way that asserts two bits.
- On a source handshake:
  - the buffer loads `sa_BID_i`/`sa_BRESP_i` of `grant`, and valid is set to 1;
  - `rr_ptr <= (grant==SLV_AMT-1) ? 0 : grant+1`.
- On `m_BVALID_o & m_BREADY_i` with no source handshake, valid clears to 0. BID/BRESP hold their last value.
- `rr_ptr` changes only on a source handshake.
- Outstanding counter `oc`, width `$clog2(OUTSTANDING_AMT+1)`:
  - increments on `AW_shift_en_i`;
  - decrements on master handshake `m_BVALID_o & m_BREADY_i`;
  - both in the same cycle leave it unchanged.
- `AW_stall_o = (oc == OUTSTANDING_AMT)`. This is combinational from the register.
- Counter boundary rules:
  - An increment at full is a protocol error. `oc` saturates at `OUTSTANDING_AMT`.
  - A decrement at 0 saturates at 0.

## Timing
- Reset values:
  - `m_BVALID_o=0`, `m_BID_o=0`, `m_BRESP_o=0`, `rr_ptr=0`, `oc=0`.
  - Consequently `AW_stall_o=0` and `sa_BREADY_o=0` while no source is valid.
- Reset asserted mid-operation discards the buffered response and clears the counter immediately, asynchronously.
- Latency: a source handshake in cycle N gives `m_BVALID_o=1` with that data from cycle N+1.
- Throughput is one response per cycle when `m_BREADY_i` is held high.
- `m_BVALID_o` is never deasserted without a master handshake. The payload is stable while `m_BVALID_o & ~m_BREADY_i`.
- A source stalled by its neighbours waits at most `SLV_AMT-1` grants.

## Configuration
- `DSP_WRESP_RR_EN`:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, where the lowest index with `sa_BVALID_i` set wins. `rr_ptr` is absent, and the fairness bound does not apply.
- Buffer, latency and counter behaviour are identical in both builds.

## Test plan
- Single source: source 1 presents BID=0x0A, BRESP=2 with `m_BREADY_i=1`. Expect `sa_BREADY_o=2'b10` that cycle, then the next cycle `m_BVALID_o=1`, `m_BID_o=0x0A`, `m_BRESP_o=2`.
- Contention under RR: both sources hold valid for 4 cycles with `m_BREADY_i=1`. Grant order must be 0,1,0,1. With `DSP_WRESP_RR_EN` undefined, the order must be 0,0,0,0.
- Backpressure: `m_BREADY_i=0` with one response buffered and both sources valid. Expect `sa_BREADY_o=0` and the payload stable for 5 cycles. Raising `m_BREADY_i` gives a handshake and the next grant in the same cycle.
- Outstanding limit at `OUTSTANDING_AMT=8`:
  - 8 `AW_shift_en_i` pulses give `AW_stall_o=1`.
  - One master B handshake clears it the next cycle.
  - A simultaneous AW pulse and B handshake at `oc=8` keeps it at 8, stall high.
- Reset mid-operation: assert `ARESETn_i=0` while `m_BVALID_o=1` and `oc=3`. Expect `m_BVALID_o=0`, `oc=0` and `AW_stall_o=0` immediately. After release, the first grant goes to source 0.
